// File: rtl/sha256_pkg.sv
// Shared SHA-256 sequencer definitions: FSM state encoding, initial hash value
// and round count.
package sha256_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_BLK = 3'd1,
      ST_LOAD     = 3'd2,
      ST_ROUND    = 3'd3,
      ST_ADD      = 3'd4,
      ST_DONE     = 3'd5
   } seq_state_t;

   localparam int unsigned NUM_ROUNDS = 64;
   localparam logic [5:0]  LAST_ROUND = 6'(NUM_ROUNDS - 1);

   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // One 32-bit lane of the chaining add; carries never cross lanes.
   function automatic logic [31:0] lane_add(input logic [31:0] x, input logic [31:0] y);
      return x + y;
   endfunction

endpackage

// File: rtl/sha256_chain_add.sv
// Eight-lane word-wise modulo-2^32 adder that folds the compressed working
// variables back into the chaining value.
module sha256_chain_add
   import sha256_pkg::*;
(
   input  logic [255:0] chain,
   input  logic [255:0] comp,
   output logic [255:0] sum
);

   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign sum[32*i +: 32] = lane_add(chain[32*i +: 32], comp[32*i +: 32]);
   end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Block-level control for a SHA-256 compression core: accepts message blocks,
// sequences load/64 rounds/chain add, and publishes the final digest.
module sha256_block_sequencer
   import sha256_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic         blk_valid,
   input  logic         blk_last,
   output logic         blk_ready,
   output logic         init_load,
   output logic         round_en,
   output logic [5:0]   round_idx,
   input  logic [255:0] comp_state,
   output logic [255:0] chain_hash,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         busy
);

   seq_state_t   state_r;
   logic         last_r;
   logic [5:0]   round_idx_r;
   logic [255:0] chain_hash_r;
   logic [255:0] digest_r;
   logic         blk_ready_r;
   logic         init_load_r;
   logic         round_en_r;
   logic         digest_valid_r;
   logic         busy_r;
   logic [255:0] sum_s;

   sha256_chain_add u_chain_add (
      .chain (chain_hash_r),
      .comp  (comp_state),
      .sum   (sum_s)
   );

   // Sequencer FSM; every output is registered alongside the state transition.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         last_r         <= 1'b0;
         round_idx_r    <= 6'd0;
         chain_hash_r   <= 256'd0;
         digest_r       <= 256'd0;
         blk_ready_r    <= 1'b0;
         init_load_r    <= 1'b0;
         round_en_r     <= 1'b0;
         digest_valid_r <= 1'b0;
         busy_r         <= 1'b0;
      end else if (abort) begin
         // Hash state is kept so a caller can still read the last chaining value.
         state_r        <= ST_IDLE;
         round_idx_r    <= 6'd0;
         blk_ready_r    <= 1'b0;
         init_load_r    <= 1'b0;
         round_en_r     <= 1'b0;
         digest_valid_r <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  chain_hash_r <= SHA256_IV;
                  state_r      <= ST_WAIT_BLK;
                  blk_ready_r  <= 1'b1;
                  busy_r       <= 1'b1;
               end
            end
            ST_WAIT_BLK: begin
               if (blk_valid && blk_ready_r) begin
                  last_r      <= blk_last;
                  state_r     <= ST_LOAD;
                  blk_ready_r <= 1'b0;
                  init_load_r <= 1'b1;
               end
            end
            ST_LOAD: begin
               state_r     <= ST_ROUND;
               init_load_r <= 1'b0;
               round_en_r  <= 1'b1;
               round_idx_r <= 6'd0;
            end
            ST_ROUND: begin
               if (round_idx_r == LAST_ROUND) begin
                  state_r     <= ST_ADD;
                  round_en_r  <= 1'b0;
                  round_idx_r <= 6'd0;
               end else begin
                  round_idx_r <= round_idx_r + 6'd1;
               end
            end
            ST_ADD: begin
               chain_hash_r <= sum_s;
               if (last_r) begin
                  digest_r       <= sum_s;
                  digest_valid_r <= 1'b1;
                  state_r        <= ST_DONE;
               end else begin
                  blk_ready_r <= 1'b1;
                  state_r     <= ST_WAIT_BLK;
               end
            end
            ST_DONE: begin
               digest_valid_r <= 1'b0;
               busy_r         <= 1'b0;
               state_r        <= ST_IDLE;
            end
            default: begin
               state_r        <= ST_IDLE;
               round_idx_r    <= 6'd0;
               blk_ready_r    <= 1'b0;
               init_load_r    <= 1'b0;
               round_en_r     <= 1'b0;
               digest_valid_r <= 1'b0;
               busy_r         <= 1'b0;
            end
         endcase
      end
   end

   assign blk_ready    = blk_ready_r;
   assign init_load    = init_load_r;
   assign round_en     = round_en_r;
   assign round_idx    = round_idx_r;
   assign chain_hash   = chain_hash_r;
   assign digest       = digest_r;
   assign digest_valid = digest_valid_r;
   assign busy         = busy_r;

endmodule
